// File: rtl/harvard_pkg.sv
// Shared types for the parametrised Harvard accumulator core.
package harvard_pkg;

    typedef enum logic [3:0] {
        OpNop  = 4'h0,
        OpLdi  = 4'h1,
        OpLd   = 4'h2,
        OpSt   = 4'h3,
        OpAdd  = 4'h4,
        OpSub  = 4'h5,
        OpAnd  = 4'h6,
        OpOr   = 4'h7,
        OpXor  = 4'h8,
        OpAddi = 4'h9,
        OpJmp  = 4'hA,
        OpJz   = 4'hB,
        OpJc   = 4'hC,
        OpOut  = 4'hD,
        OpRsv  = 4'hE,
        OpHalt = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        StFetch,
        StExec,
        StMem,
        StHalt
    } state_t;

    function automatic int unsigned instr_w(int unsigned addr_w);
        return 4 + addr_w;
    endfunction

    // Opcodes LD..XOR go through the data-memory handshake.
    function automatic logic is_mem_op(opcode_t op);
        return (op >= OpLd) && (op <= OpXor);
    endfunction

endpackage

// File: rtl/harvard_core_p_alu.sv
// Combinational accumulator ALU; b_i is either the immediate or the memory word.
module harvard_alu
    import harvard_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o,
    output logic              zero_o
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, acc_i} + {1'b0, b_i};
    // MSB of the widened difference is the borrow (acc < b).
    assign diff = {1'b0, acc_i} - {1'b0, b_i};

    always_comb begin
        result_o = acc_i;
        carry_o  = 1'b0;
        case (opcode_t'(op_i))
            OpLdi, OpLd:   result_o = b_i;
            OpAdd, OpAddi: {carry_o, result_o} = sum;
            OpSub:         {carry_o, result_o} = diff;
            OpAnd:         result_o = acc_i & b_i;
            OpOr:          result_o = acc_i | b_i;
            OpXor:         result_o = acc_i ^ b_i;
            default:       ;
        endcase
        zero_o = (result_o == '0);
    end

endmodule

// File: rtl/harvard_core_p.sv
// Multicycle accumulator core: FETCH/EXEC/MEM/HALT FSM with a req/ack data port.
module harvard_core_p
    import harvard_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [ADDR_W+3:0] imem_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted
);

    localparam int unsigned INSTR_W = instr_w(ADDR_W);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                z_q, z_d;
    logic                c_q, c_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;

    opcode_t             op;
    logic [ADDR_W-1:0]   operand;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   alu_b;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_c;
    logic                alu_z;
    logic                mem_op;

    assign op      = opcode_t'(ir_q[INSTR_W-1 -: 4]);
    assign operand = ir_q[ADDR_W-1:0];
    assign mem_op  = is_mem_op(op);

    // Zero-extend or truncate the operand field to the data width.
    always_comb begin
        imm = '0;
        for (int i = 0; i < int'(DATA_W) && i < int'(ADDR_W); i++) begin
            imm[i] = operand[i];
        end
    end

    assign alu_b = (op == OpLdi || op == OpAddi) ? imm : dmem_rdata;

    harvard_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i     (ir_q[INSTR_W-1 -: 4]),
        .acc_i    (acc_q),
        .b_i      (alu_b),
        .result_o (alu_res),
        .carry_o  (alu_c),
        .zero_o   (alu_z)
    );

    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == StExec || state_q == StMem) && mem_op;
    assign dmem_we    = (op == OpSt);
    assign dmem_addr  = operand;
    assign dmem_wdata = acc_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign halted     = (state_q == StHalt);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        acc_d       = acc_q;
        z_d         = z_q;
        c_d         = c_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        unique case (state_q)
            StFetch: begin
                ir_d    = imem_data;
                pc_d    = pc_q + 1'b1;
                state_d = StExec;
            end
            StExec, StMem: begin
                if (mem_op && !dmem_ack) begin
                    state_d = StMem;
                end else begin
                    state_d = StFetch;
                    case (op)
                        OpLdi, OpLd, OpAnd, OpOr, OpXor: begin
                            acc_d = alu_res;
                            z_d   = alu_z;
                        end
                        OpAdd, OpSub, OpAddi: begin
                            acc_d = alu_res;
                            z_d   = alu_z;
                            c_d   = alu_c;
                        end
                        OpJmp: pc_d = operand;
                        OpJz:  if (z_q) pc_d = operand;
                        OpJc:  if (c_q) pc_d = operand;
                        OpOut: begin
                            out_data_d  = acc_q;
                            out_valid_d = 1'b1;
                        end
                        OpHalt: state_d = StHalt;
                        default: ;
                    endcase
                end
            end
            StHalt: state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StFetch;
            pc_q        <= '0;
            ir_q        <= '0;
            acc_q       <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            acc_q       <= acc_d;
            z_q         <= z_d;
            c_q         <= c_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_harvard_core_p.sv
// Directed programs against an 8/8 core and a 16/10 core with ROM/RAM models.
module tb_harvard_core_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset   = 1'b1;
    logic reset16 = 1'b1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- 8/8 core ----------------
    logic [7:0]  imem_addr;
    logic [11:0] imem_data;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata, out_data;
    logic        out_valid, halted;

    logic [11:0] rom [256];
    logic [7:0]  ram [256];
    int          ack_delay = 0;
    int          wait_cnt  = 0;

    assign imem_data  = rom[imem_addr];
    assign dmem_rdata = ram[dmem_addr];
    assign dmem_ack   = dmem_req && (wait_cnt >= ack_delay);

    always @(posedge clk) begin
        if (dmem_req && !dmem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (dmem_req && dmem_ack && dmem_we) ram[dmem_addr] <= dmem_wdata;
    end

    harvard_core_p #(
        .DATA_W (8),
        .ADDR_W (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .halted     (halted)
    );

    logic [7:0] outs [$];
    logic [7:0] hold_addr, hold_wdata;
    logic       hold_we;
    logic       hold_valid = 1'b0;
    int         unstable   = 0;
    int         req_cycles = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (dmem_req) begin
                req_cycles++;
                if (hold_valid && (dmem_addr !== hold_addr || dmem_wdata !== hold_wdata ||
                                   dmem_we !== hold_we))
                    unstable++;
                hold_valid = !dmem_ack;
                hold_addr  = dmem_addr;
                hold_wdata = dmem_wdata;
                hold_we    = dmem_we;
            end else begin
                hold_valid = 1'b0;
            end
            if (out_valid) outs.push_back(out_data);
        end
    end

    // ---------------- 16/10 core ----------------
    logic [9:0]  imem_addr16;
    logic [13:0] imem_data16;
    logic        dmem_req16, dmem_we16;
    logic [9:0]  dmem_addr16;
    logic [15:0] dmem_wdata16, out_data16;
    logic        out_valid16, halted16;
    logic [13:0] rom16 [1024];
    logic [15:0] outs16 [$];

    assign imem_data16 = rom16[imem_addr16];

    harvard_core_p #(
        .DATA_W (16),
        .ADDR_W (10)
    ) dut16 (
        .clk        (clk),
        .reset      (reset16),
        .imem_addr  (imem_addr16),
        .imem_data  (imem_data16),
        .dmem_req   (dmem_req16),
        .dmem_we    (dmem_we16),
        .dmem_addr  (dmem_addr16),
        .dmem_wdata (dmem_wdata16),
        .dmem_rdata (16'h0000),
        .dmem_ack   (dmem_req16),
        .out_data   (out_data16),
        .out_valid  (out_valid16),
        .halted     (halted16)
    );

    always @(negedge clk) if (!reset16 && out_valid16) outs16.push_back(out_data16);

    // ---------------- helpers ----------------
    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 12'hF00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        outs.delete();
        req_cycles = 0;
        unstable   = 0;
        reset      = 1'b0;
    endtask

    task automatic run_to_halt(output int cycles);
        cycles = 0;
        while (!halted && cycles < 300) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    int cyc;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;

        // Straight-line: LDI 5; ADDI 3; OUT; HALT.
        clear_rom();
        rom[0] = 12'h105; rom[1] = 12'h903; rom[2] = 12'hD00; rom[3] = 12'hF00;
        do_reset();
        check("rst_imem_addr", imem_addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_dmem_req", dmem_req, 0);
        run_to_halt(cyc);
        check("s1_halted", halted, 1);
        check("s1_cycles", cyc, 8);
        check("s1_out_count", outs.size(), 1);
        if (outs.size() > 0) check("s1_out", outs[0], 8'h08);
        check("s1_pc", imem_addr, 8'h04);

        // Carry and borrow, JC taken twice.
        clear_rom();
        ack_delay = 0;
        ram[8'h10] = 8'h20; ram[8'h11] = 8'h20;
        rom[0] = 12'h1F0; rom[1] = 12'h410; rom[2] = 12'hD00; rom[3] = 12'hC05;
        rom[4] = 12'hF00; rom[5] = 12'h511; rom[6] = 12'hD00; rom[7] = 12'hC09;
        rom[8] = 12'hF00; rom[9] = 12'hF00;
        do_reset();
        run_to_halt(cyc);
        check("s2_cycles", cyc, 16);
        check("s2_pc", imem_addr, 8'h0A);
        check("s2_out_count", outs.size(), 2);
        if (outs.size() > 1) begin
            check("s2_add", outs[0], 8'h10);
            check("s2_sub", outs[1], 8'hF0);
        end

        // Wait states: ST then LD with ack three cycles late.
        clear_rom();
        ack_delay = 3;
        ram[8'h40] = 8'h00;
        rom[0] = 12'h15A; rom[1] = 12'h340; rom[2] = 12'h100; rom[3] = 12'h240;
        rom[4] = 12'hD00; rom[5] = 12'hF00;
        do_reset();
        run_to_halt(cyc);
        check("s3_cycles", cyc, 18);
        check("s3_req_cycles", req_cycles, 8);
        check("s3_unstable", unstable, 0);
        check("s3_ram", ram[8'h40], 8'h5A);
        check("s3_out_count", outs.size(), 1);
        if (outs.size() > 0) check("s3_ld", outs[0], 8'h5A);

        // Zero-flag loop: three ADDI 0xFF iterations then JZ to end.
        clear_rom();
        ack_delay = 0;
        rom[0] = 12'h103; rom[1] = 12'h9FF; rom[2] = 12'hB04; rom[3] = 12'hA01;
        rom[4] = 12'hD00; rom[5] = 12'hF00;
        do_reset();
        run_to_halt(cyc);
        check("s4_cycles", cyc, 22);
        check("s4_pc", imem_addr, 8'h06);
        check("s4_out_count", outs.size(), 1);
        if (outs.size() > 0) check("s4_acc", outs[0], 8'h00);

        // PC wrap through reserved opcode at 0xFF.
        clear_rom();
        rom[8'h00] = 12'hB10; rom[8'h01] = 12'hAFE; rom[8'hFE] = 12'h100;
        rom[8'hFF] = 12'hE00; rom[8'h10] = 12'hD00; rom[8'h11] = 12'hF00;
        do_reset();
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        check("s5_wrap_pc", imem_addr, 8'h00);
        run_to_halt(cyc);
        check("s5_cycles", cyc, 7);
        check("s5_pc", imem_addr, 8'h12);
        check("s5_out_count", outs.size(), 1);

        // Reset while a read is stalled in MEM.
        clear_rom();
        ack_delay = 20;
        ram[8'h20] = 8'h77;
        rom[0] = 12'h109; rom[1] = 12'h220;
        do_reset();
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("s6_req_in_mem", dmem_req, 1);
        check("s6_addr_in_mem", dmem_addr, 8'h20);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("s6_req_dropped", dmem_req, 0);
        check("s6_pc", imem_addr, 8'h00);
        rom[0] = 12'hD00; rom[1] = 12'hF00;
        @(negedge clk);
        outs.delete();
        reset = 1'b0;
        run_to_halt(cyc);
        check("s6_cycles", cyc, 4);
        check("s6_out_count", outs.size(), 1);
        if (outs.size() > 0) check("s6_acc", outs[0], 8'h00);

        // 16/10 core: LDI 0x3FF; OUT; ADDI 3; OUT; HALT.
        for (int i = 0; i < 1024; i++) rom16[i] = 14'h3C00;
        rom16[0] = {4'h1, 10'h3FF};
        rom16[1] = {4'hD, 10'h000};
        rom16[2] = {4'h9, 10'h003};
        rom16[3] = {4'hD, 10'h000};
        rom16[4] = {4'hF, 10'h000};
        repeat (2) @(negedge clk);
        check("p_rst_out", out_data16, 0);
        outs16.delete();
        reset16 = 1'b0;
        cyc = 0;
        while (!halted16 && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("p_cycles", cyc, 10);
        check("p_pc", imem_addr16, 10'h005);
        check("p_out_count", outs16.size(), 2);
        if (outs16.size() > 1) begin
            check("p_imm_zext", outs16[0], 16'h03FF);
            check("p_addi", outs16[1], 16'h0402);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/harvard_core_p.md
# harvard_core_p

Parametrised multicycle accumulator processor with separate instruction and data memory ports. It is the next generation of the team's fixed-width Harvard core, adding:
- configurable data and address widths;
- a data-memory request/acknowledge handshake with wait states;
- an output port;
- an explicit halt state.

It sits between an external instruction ROM (combinational read) and a data RAM or peripheral bus. The top-level testbench instantiates it with only `clk` and `reset` driven internally.

## Interface
- `DATA_W`, 8: accumulator and data-bus width, ≥4.
- `ADDR_W`, 8: PC and data-address width. Instruction width is `INSTR_W = 4 + ADDR_W`.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `imem_addr` output `ADDR_W`: equals PC.
- `imem_data` input `INSTR_W`: instruction at `imem_addr`, combinational. Encoding is `{opcode[3:0], operand[ADDR_W-1:0]}`.
- `dmem_req` output 1: data access request.
- `dmem_we` output 1: 1 = write, 0 = read. Valid while `dmem_req` is high.
- `dmem_addr` output `ADDR_W`: data address.
- `dmem_wdata` output `DATA_W`: store data.
- `dmem_rdata` input `DATA_W`: sampled in the cycle `dmem_ack` is high.
- `dmem_ack` input 1: completes the access. It may be high in the same cycle as the request.
- `out_data` output `DATA_W`: last value written by OUT.
- `out_valid` output 1: one-cycle pulse per OUT.
- `halted` output 1: high while in HALT.

## Operation
- The immediate `imm` is the operand field zero-extended or truncated to `DATA_W`.
- `mem` means the data read at `operand`.
- Flags:
  - Z is set when the accumulator result is zero. It is updated on every accumulator write.
  - C is updated only by ADD, SUB and ADDI. C is the carry-out for ADD/ADDI and the borrow for SUB (C=1 if acc < mem).
- Opcodes:
  - 0 NOP.
  - 1 LDI: acc←imm.
  - 2 LD: acc←mem.
  - 3 ST: mem←acc.
  - 4 ADD: acc←acc+mem.
  - 5 SUB: acc←acc−mem.
  - 6 AND, 7 OR, 8 XOR: acc←acc op mem.
  - 9 ADDI: acc←acc+imm.
  - A JMP: pc←operand.
  - B JZ: jump if Z.
  - C JC: jump if C.
  - D OUT: `out_data`←acc and pulse `out_valid`.
  - E reserved: executes as NOP.
  - F HALT.
- Arithmetic is modulo 2^`DATA_W`.
- PC increments modulo 2^`ADDR_W`; 0xFF+1 wraps to 0x00 for `ADDR_W`=8.
- States:
  - FETCH: latch `imem_data` into IR, pc←pc+1, go to EXEC.
  - EXEC:
    - Non-memory opcodes commit and return to FETCH.
    - Opcodes 2–8 assert `dmem_req` (with `dmem_we`=1 for ST).
    - If `dmem_ack` is high, commit and go to FETCH. Otherwise go to MEM.
    - HALT goes to HALT.
  - MEM: hold `dmem_req`, `dmem_addr`, `dmem_we` and `dmem_wdata` stable until `dmem_ack` is high, then commit and go to FETCH.
  - HALT: terminal. Only `reset` exits. No memory requests are issued.
- `dmem_ack` while `dmem_req` is low is ignored.
- Reset while in MEM drops `dmem_req` on the next edge. The pending access is abandoned and never committed.

## Timing
- Reset values: pc=0, acc=0, Z=0, C=0, state=FETCH. All outputs are 0 (`imem_addr`=0, `out_data`=0, `halted`=0).
- Non-memory instruction: 2 cycles.
- Memory instruction: 2+N cycles, where N is the number of cycles `dmem_ack` is low after the request first rises. Zero-wait access takes 2 cycles.
- `dmem_req` is combinational from state and IR. It is high in EXEC and MEM for opcodes 2–8.
- `out_valid` is registered: high for the one cycle following the OUT EXEC edge.
- `halted` rises on the edge leaving EXEC of HALT.
- A taken jump's target appears on `imem_addr` in the next FETCH. There is no delay slot.

## Structure
- Package `harvard_pkg`:
  - opcode enum `opcode_t`;
  - state enum `state_t` (FETCH, EXEC, MEM, HALT);
  - localparam function for `INSTR_W`.
- Sub-module `harvard_alu`: combinational, parametrised by `DATA_W`. Takes the opcode, acc and operand; returns the result, carry and zero.
- The top level holds the FSM, PC, IR, acc, flags and output registers.

## Test plan
- Reset and straight-line run:
  - Program LDI 5; ADDI 3; OUT; HALT.
  - Required: `out_data`=8 with one `out_valid` pulse, then `halted`=1 at cycle 8 after reset release, and Z=0.
- Carry and borrow (`DATA_W`=8):
  - Program LDI 0xF0; ADD [0x10] with mem[0x10]=0x20 → acc=0x10, C=1.
  - Then SUB [0x11] with mem[0x11]=0x20 → acc=0xF0, C=1.
  - JC taken.
- Wait states:
  - Program ST [0x40]; LD [0x40], with ack delayed 3 cycles.
  - Required: req/addr/we/wdata stable throughout the wait, each instruction takes 5 cycles, and acc equals the stored value.
- Zero flag and loop:
  - Program LDI 3; loop: ADDI 0xFF; JZ end; JMP loop.
  - Required: exactly 3 ADDI executions, then the branch reaches end.
- Boundaries:
  - JMP 0xFF executing NOP wraps PC to 0x00.
  - Reset asserted during MEM: req low the next cycle, acc unchanged, pc=0.
  - Opcode E behaves as NOP.
- Parametrisation:
  - Rerun the first scenario with `DATA_W`=16, `ADDR_W`=10 and LDI 0x3FF.
  - Required: immediate zero-extends to 0x03FF.
